keys_pio: RTL

- Avalon-MM slave input PIO for push-buttons/switches; the read-side counterpart of the LED output port.
- Samples an asynchronous `in_port` and synchronizes it, then debounces each bit.
- Captures rising edges per bit and raises a maskable level interrupt to the Nios II.
- Zero-wait-state slave: read latency 0, combinational `readdata`.

---
 rtl/keys_pio.sv | 103 ++++++++++
 1 files changed

// File: rtl/keys_pio.sv
`default_nettype none
// ============================================================================
// Module   : keys_pio
// Brief    : Avalon-MM input PIO with 2-flop synchronizer, per-bit debounce,
//            rising-edge capture and maskable level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module keys_pio #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [DATA_WIDTH-1:0] r_s1;
    logic [DATA_WIDTH-1:0] r_s2;
    logic [DATA_WIDTH-1:0] r_filt;
    logic [DATA_WIDTH-1:0] r_filt_d;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_edge;
    logic [CNT_WIDTH-1:0]  r_cnt [DATA_WIDTH];

    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_rise;
    logic [DATA_WIDTH-1:0] w_clr;

    assign w_wr   = chipselect & ~write_n;
    assign w_rise = r_filt & ~r_filt_d;
    assign w_clr  = (w_wr && address == 2'd3) ? writedata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

    // A bit only moves once it has disagreed with filt for DEBOUNCE_CYCLES edges in a row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt <= '0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (r_s2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_CNT_MAX) begin
                    r_filt[i] <= r_s2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // New edges win over a simultaneous write-1-to-clear of the same bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt_d <= '0;
            r_mask   <= '0;
            r_edge   <= '0;
        end else begin
            r_filt_d <= r_filt;
            r_edge   <= (r_edge & ~w_clr) | w_rise;
            if (w_wr && address == 2'd2) begin
                r_mask <= writedata;
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                2'd0:    readdata = r_filt;
                2'd2:    readdata = r_mask;
                2'd3:    readdata = r_edge;
                default: readdata = '0;
            endcase
        end
    end

    assign irq = |(r_edge & r_mask);

endmodule
`default_nettype wire
